if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  IF-stage front half: holds PC register, issues instruction-ROM reads, buffers {pc,inst} pairs for ID.
//  Exports if_pc to the next-PC logic and consumes its npc/jump_taken.
//  Redirects on jump_taken, flushing buffered and in-flight fetches.
// PARAMETERS
//  RESET_PC    32'h1C00_0000  PC value loaded on reset (LA32R boot vector)
//  FIFO_DEPTH  2              fetch-buffer entries; power of two, >= 2
// PORTS
//  cpu_clk     in   1   single clock, rising edge
//  cpu_rstn    in   1   asynchronous, active-low reset
//  if_pc       out  32  current fetch PC, to next-PC logic
//  npc         in   32  next PC from next-PC logic (pc+4 or redirect target)
//  jump_taken  in   1   redirect strobe; npc holds target this cycle
//  irom_req    out  1   instruction read request
//  irom_addr   out  32  read address; equals if_pc at issue
//  irom_ack    in   1   read complete; irom_rdata valid this cycle
//  irom_rdata  in   32  instruction word
//  id_valid    out  1   buffer head valid
//  id_ready    in   1   ID accepts head this cycle
//  id_pc       out  32  PC of head instruction
//  id_inst     out  32  head instruction word
// BEHAVIOUR
//  Reset: if_pc=RESET_PC; irom_req=0; id_valid=0; FIFO empty; state=REQ; perf counters 0.
//  States: REQ (request when FIFO not full), WAIT (outstanding, not acked), DISCARD (outstanding, stale).
//  REQ & !full: irom_req=1, irom_addr=if_pc. Ack same cycle -> push {if_pc,rdata}, if_pc<=npc, stay REQ.
//    No ack -> WAIT. REQ & full: irom_req=0, hold.
//  WAIT: irom_req=1, irom_addr stable until irom_ack. Ack -> push, if_pc<=npc, REQ.
//  At most one outstanding request; ack never arrives without req.
//  jump_taken: FIFO flushed; id_valid=0 next cycle; if_pc<=npc[31:2],2'b00.
//    Redirect in REQ with ack, or WAIT with ack: rdata dropped, go REQ.
//    Redirect in WAIT without ack: go DISCARD, keep req/addr stable; drop next ack's data, then REQ.
//    Redirect in DISCARD: update if_pc, stay DISCARD.
//  Simultaneous pop (id_valid&id_ready) and push: both occur; count unchanged.
//  Simultaneous pop and jump_taken: flush wins; popped entry is the last one consumed.
//  FIFO: first-word-fall-through; id_pc/id_inst driven from head; pointers wrap modulo FIFO_DEPTH.
//  if_pc[1:0] always 2'b00; npc[1:0] ignored. Fetch latency: ack cycle -> id_valid next cycle.
//  Reset assertion mid-request: all state cleared asynchronously; a late ack after release is ignored
//    (state REQ with irom_req=0 in first post-reset cycle).
// CONFIGURATION
//  IF_PERF_CNT_EN defined: adds outputs perf_fetch_cnt[31:0] (+1 per pushed instruction) and
//    perf_stall_cnt[31:0] (+1 per cycle in WAIT/DISCARD or REQ&full); both wrap at 2^32, reset to 0.
//  Undefined: ports and counters absent; no other behaviour change.
// STRUCTURE
//  defines.vh: IF state encodings, `RESET_PC default, FIFO entry width (64).
//  Sub-module if_inst_fifo: sync FWFT FIFO, push/pop/flush, full/empty, {pc,inst} entries.
//  Top: FSM, PC register, redirect handling, optional perf counters.
// TESTING
//  Reset release, irom_ack tied 1, id_ready 1 -> irom_addr 0x1C000000,0x1C000004,...; id_pc follows 1 cycle later.
//  irom_ack 3-cycle latency -> irom_addr stable 0x1C000000 over 3 cycles; single push; id_inst=rdata.
//  id_ready=0 for 6 cycles, ack=1 -> exactly 2 pushes, irom_req=0 while full; resume pops in order.
//  jump_taken with npc=0x1C000100 while WAIT -> DISCARD, stale rdata dropped, next irom_addr=0x1C000100, id_valid=0.
//  jump_taken coincident with irom_ack and pop -> no push, FIFO empty next cycle, next fetch at target.
//  IF_PERF_CNT_EN: 10 acks, 4 stall cycles -> perf_fetch_cnt=10, perf_stall_cnt=4; reset clears both.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the IF fetch unit: FSM state encoding,
// boot vector default, fetch-buffer entry layout and a PC alignment helper.
package if_fetch_unit_pkg;

  // Fetch FSM: REQ issues when the buffer has room, WAIT holds an
  // outstanding read, DISCARD holds an outstanding read whose data is stale.
  typedef enum logic [1:0] {
    ST_REQ     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } if_state_e;

  // LA32R boot vector.
  localparam logic [31:0] IF_RESET_PC_DEFAULT = 32'h1C00_0000;

  // One buffered fetch is a {pc, inst} pair.
  localparam int unsigned IF_ENTRY_W = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_entry_t;

  // Instruction addresses are word aligned; low two bits are forced to zero.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Bus bundle of the fetch unit: instruction-ROM read handshake on one side,
// {pc, inst} hand-off to the decode stage on the other.
// master = fetch unit, slave = ROM / decode environment.
interface if_fetch_unit_if;
  logic        irom_req;
  logic [31:0] irom_addr;
  logic        irom_ack;
  logic [31:0] irom_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  modport master (
    output irom_req, irom_addr, id_valid, id_pc, id_inst,
    input  irom_ack, irom_rdata, id_ready
  );

  modport slave (
    input  irom_req, irom_addr, id_valid, id_pc, id_inst,
    output irom_ack, irom_rdata, id_ready
  );
endinterface

// File: rtl/if_fetch_unit_inst_fifo.sv
// First-word-fall-through buffer of {pc, inst} fetch entries.
// Head entry is visible combinationally while not empty. Flush empties the
// buffer and overrides a simultaneous push; a pop in the same cycle is
// simply absorbed by the flush. DEPTH must be a power of two, >= 2.
module if_fetch_unit_inst_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      cpu_clk,
  input  logic      cpu_rstn,
  input  logic      push,
  input  if_entry_t push_data,
  input  logic      pop,
  input  logic      flush,
  output logic      full,
  output logic      empty,
  output if_entry_t head_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]            wr_ptr_reg, rd_ptr_reg;
  logic [AW-1:0]          wr_idx, rd_idx;
  logic                   push_eff, pop_eff;
  logic [IF_ENTRY_W-1:0]  entry_q [DEPTH];

  assign wr_idx   = wr_ptr_reg[AW-1:0];
  assign rd_idx   = rd_ptr_reg[AW-1:0];
  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) && (wr_idx == rd_idx);
  assign push_eff = push && !full && !flush;
  assign pop_eff  = pop && !empty && !flush;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [IF_ENTRY_W-1:0] data_reg;

      // Storage slot gi: written only when the write pointer lands here.
      always_ff @(posedge cpu_clk) begin
        if (push_eff && (wr_idx == AW'(gi))) begin
          data_reg <= push_data;
        end
      end

      assign entry_q[gi] = data_reg;
    end
  endgenerate

  assign head_data = entry_q[rd_idx];

  // Pointer update; flush resets both pointers so the buffer reads empty.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_eff) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_eff)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// IF-stage front half: PC register, instruction-ROM request FSM, redirect
// handling and the {pc, inst} fetch buffer feeding decode.
// Optional feature macro: IF_PERF_CNT_EN adds fetch/stall performance counters.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = IF_RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic          cpu_clk,
  input  logic          cpu_rstn,
  output logic [31:0]   if_pc,
  input  logic [31:0]   npc,
  input  logic          jump_taken,
  if_fetch_unit_if.master bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]   perf_fetch_cnt,
  output logic [31:0]   perf_stall_cnt
`endif
);

  if_state_e   state_reg, state_next;
  logic [31:0] pc_reg, addr_reg;
  logic        started_reg;
  logic        req_c, push_c, pc_load_c;
  logic        fifo_full, fifo_empty, pop_c;
  if_entry_t   push_entry, head_entry;

  // The first cycle after reset never requests, so an ack that straggles
  // in from before the reset cannot be mistaken for a new fetch.
  always_comb begin
    state_next = state_reg;
    req_c      = 1'b0;
    push_c     = 1'b0;
    pc_load_c  = jump_taken;
    unique case (state_reg)
      ST_REQ: begin
        if (started_reg && !fifo_full) begin
          req_c = 1'b1;
          if (bus.irom_ack) begin
            push_c    = !jump_taken;
            pc_load_c = 1'b1;
          end else if (jump_taken) begin
            state_next = ST_DISCARD;
          end else begin
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        req_c = 1'b1;
        if (bus.irom_ack) begin
          push_c     = !jump_taken;
          pc_load_c  = 1'b1;
          state_next = ST_REQ;
        end else if (jump_taken) begin
          state_next = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        // Outstanding read belongs to a squashed path: swallow its data.
        req_c = 1'b1;
        if (bus.irom_ack) state_next = ST_REQ;
      end
      default: state_next = ST_REQ;
    endcase
  end

  // FSM state, PC and the address latched at issue (held while outstanding).
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_reg   <= ST_REQ;
      pc_reg      <= align_pc(RESET_PC);
      addr_reg    <= align_pc(RESET_PC);
      started_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      started_reg <= 1'b1;
      if (pc_load_c) pc_reg <= align_pc(npc);
      if ((state_reg == ST_REQ) && req_c) addr_reg <= pc_reg;
    end
  end

  assign if_pc         = pc_reg;
  assign bus.irom_req  = req_c;
  assign bus.irom_addr = (state_reg == ST_REQ) ? pc_reg : addr_reg;

  assign push_entry.pc   = pc_reg;
  assign push_entry.inst = bus.irom_rdata;
  assign pop_c           = bus.id_valid && bus.id_ready;

  if_fetch_unit_inst_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .cpu_clk   (cpu_clk),
    .cpu_rstn  (cpu_rstn),
    .push      (push_c),
    .push_data (push_entry),
    .pop       (pop_c),
    .flush     (jump_taken),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_data (head_entry)
  );

  assign bus.id_valid = !fifo_empty;
  assign bus.id_pc    = head_entry.pc;
  assign bus.id_inst  = head_entry.inst;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_reg, stall_cnt_reg;

  // Fetched-instruction and stalled-cycle counters, free-running with wrap.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      fetch_cnt_reg <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (push_c) fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
      if ((state_reg != ST_REQ) || fifo_full) stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_reg;
  assign perf_stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized scoreboard bench for if_fetch_unit. A transaction-level model
// tracks the architectural fetch stream (next PC, outstanding read, stale
// reads after redirects, buffered entries); a monitor pops the expected
// queue whenever decode accepts an entry.
`timescale 1ns/1ps
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  localparam logic [31:0] RST_PC = 32'h1C00_0000;
  localparam int          DEPTH  = 2;

  logic        cpu_clk  = 1'b0;
  logic        cpu_rstn = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] npc        = '0;
  logic        jump_taken = 1'b0;

  if_fetch_unit_if bus_if ();

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  if_fetch_unit #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .cpu_clk        (cpu_clk),
    .cpu_rstn       (cpu_rstn),
    .if_pc          (if_pc),
    .npc            (npc),
    .jump_taken     (jump_taken),
    .bus            (bus_if)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 cpu_clk = ~cpu_clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        pend_ent;
  exp_t        mon_e;
  logic [31:0] model_pc, iss_addr, pend_pc;
  bit          outst, stale, pend_push, pend_flush;
  int          lat;
  int unsigned mdl_fetch, mdl_stall;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, required %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    model_pc   = RST_PC;
    iss_addr   = RST_PC;
    pend_pc    = RST_PC;
    outst      = 1'b0;
    stale      = 1'b0;
    pend_push  = 1'b0;
    pend_flush = 1'b0;
    exp_q.delete();
    mdl_fetch  = 0;
    mdl_stall  = 0;
  endtask

  // One clock cycle, called #1 after the rising edge: apply the effects of
  // the previous cycle, check DUT outputs, then choose this cycle's inputs.
  task automatic do_cycle(input bit started, input int lat_min, input int lat_max,
                          input int jump_pct, input int ready_pct, input bit late_ack);
    bit          exp_req, ack, jump;
    logic [31:0] r, rdata, tgt;
    if (pend_flush) exp_q.delete();
    if (pend_push)  exp_q.push_back(pend_ent);
    model_pc   = pend_pc;
    pend_flush = 1'b0;
    pend_push  = 1'b0;

    exp_req = started && (outst || (exp_q.size() < DEPTH));
    check32("if_pc", if_pc, model_pc);
    check1("id_valid", bus_if.id_valid, exp_q.size() > 0);
    check1("irom_req", bus_if.irom_req, exp_req);
`ifdef IF_PERF_CNT_EN
    check32("perf_fetch_cnt", perf_fetch_cnt, mdl_fetch);
    check32("perf_stall_cnt", perf_stall_cnt, mdl_stall);
`endif
    if (started && (outst || (exp_q.size() == DEPTH))) mdl_stall++;

    if (exp_req) begin
      if (!outst) begin
        outst    = 1'b1;
        stale    = 1'b0;
        iss_addr = model_pc;
        lat      = int'($urandom_range(lat_max, lat_min));
      end
      check32("irom_addr", bus_if.irom_addr, iss_addr);
    end

    ack = 1'b0;
    if (outst) begin
      if (lat == 0) ack = 1'b1;
      else lat--;
    end

    r     = $urandom;
    rdata = $urandom;
    jump  = ($urandom_range(99, 0) < jump_pct);
    tgt   = RST_PC + ((r & 32'hFF) << 4) + (r >> 30);

    bus_if.irom_ack   = ack || late_ack;
    bus_if.irom_rdata = rdata;
    bus_if.id_ready   = ($urandom_range(99, 0) < ready_pct);
    jump_taken        = jump;
    npc               = jump ? tgt : ((model_pc + 32'd4) | (r & 32'h3));

    pend_pc = model_pc;
    if (jump) begin
      pend_flush = 1'b1;
      pend_pc    = {tgt[31:2], 2'b00};
      if (outst) begin
        if (ack) outst = 1'b0;
        else     stale = 1'b1;
      end
    end else if (ack) begin
      outst = 1'b0;
      if (!stale) begin
        pend_push     = 1'b1;
        pend_ent.pc   = iss_addr;
        pend_ent.inst = rdata;
        pend_pc       = iss_addr + 32'd4;
        mdl_fetch++;
      end
    end
  endtask

  task automatic run(input int n, input int lat_min, input int lat_max,
                     input int jump_pct, input int ready_pct);
    repeat (n) begin
      @(posedge cpu_clk);
      #1;
      do_cycle(1'b1, lat_min, lat_max, jump_pct, ready_pct, 1'b0);
    end
  endtask

  task automatic reset_checks();
    check32("rst_if_pc", if_pc, RST_PC);
    check1("rst_irom_req", bus_if.irom_req, 1'b0);
    check1("rst_id_valid", bus_if.id_valid, 1'b0);
  endtask

  // Scoreboard monitor: every accepted head entry must match the oldest
  // expected fetch.
  always @(negedge cpu_clk) begin
    if (cpu_rstn && bus_if.id_valid && bus_if.id_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pop_empty: got pc %h inst %h, required no valid entry", bus_if.id_pc, bus_if.id_inst);
      end else begin
        mon_e = exp_q.pop_front();
        check32("id_pc", bus_if.id_pc, mon_e.pc);
        check32("id_inst", bus_if.id_inst, mon_e.inst);
        $display("pop pc=%h inst=%h (expected pc=%h inst=%h)", bus_if.id_pc, bus_if.id_inst, mon_e.pc, mon_e.inst);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.irom_ack   = 1'b0;
    bus_if.irom_rdata = '0;
    bus_if.id_ready   = 1'b0;
    model_reset();

    // Reset state, then release with a late ack in the first cycle.
    repeat (3) @(posedge cpu_clk);
    #1;
    reset_checks();
    @(posedge cpu_clk);
    #1;
    cpu_rstn = 1'b1;
    do_cycle(1'b0, 0, 0, 0, 100, 1'b1);

    run(40, 0, 0, 0, 100);   // back-to-back fetch, always accepted
    run(30, 2, 2, 0, 100);   // fixed 3-cycle ROM latency
    run(12, 0, 0, 0, 0);     // decode stalled: buffer fills, requests stop
    run(20, 0, 1, 0, 100);   // drain in order
    run(300, 0, 3, 12, 70);  // redirects mixed with latency and back-pressure

    // Reset asserted in the middle of a cycle with traffic in flight.
    @(posedge cpu_clk);
    #3;
    cpu_rstn = 1'b0;
    #1;
    reset_checks();
    bus_if.irom_ack = 1'b0;
    bus_if.id_ready = 1'b0;
    jump_taken      = 1'b0;
    model_reset();
    repeat (2) @(posedge cpu_clk);
    #1;
    cpu_rstn = 1'b1;
    do_cycle(1'b0, 0, 0, 0, 100, 1'b1);

    run(200, 0, 3, 8, 60);
    run(10, 0, 0, 0, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
